float_subtractor: RTL and testbench
===================================

Name: float_subtractor

Overview:
- Multi-cycle IEEE-754 single-precision subtractor; computes diff = a - b.
- Pairs with the combinational float adder in the XOR network datapath; used by the weight-update and error stages (target - output, w - lr*grad).
- Valid/ready handshakes on both sides; FSM-sequenced align, add/subtract and iterative normalise.
- Rounding is truncation toward zero; denormals are flushed to zero.

Parameters:
- GUARD_BITS, 3, extra low-order mantissa bits kept through align and normalise; internal magnitude width = 24 + GUARD_BITS + 1 carry bit.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  32  minuend, IEEE-754 single.
- b  input  32  subtrahend, IEEE-754 single.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- diff  output  32  result, registered.
- out_valid  output  1  diff valid.
- out_ready  input  1  consumer accepts diff.

Behaviour:
- Reset, asynchronous, takes effect immediately: state=IDLE, in_ready=1, out_valid=0, diff=0x00000000, all internal registers cleared.
- Reset asserted mid-operation aborts the operation with no output.
- FSM states: IDLE, ALIGN, ADDSUB, NORM, OUT.
- IDLE: in_valid&&in_ready at an edge does three things:
  - captures a and b with b's sign inverted;
  - treats exp==0 as zero, with the hidden bit forced to 0 and the mantissa to 0;
  - moves to ALIGN.
- ALIGN (1 cycle):
  - swaps operands so the larger magnitude is in the "big" register, comparing exponent first, then mantissa;
  - right-shifts the small mantissa by the exponent difference;
  - shifted-out bits are discarded (no sticky bit); a difference >= 24+GUARD_BITS leaves the small mantissa at 0.
- ADDSUB (1 cycle):
  - equal effective signs: big+small;
  - otherwise: big-small, never negative.
  - Result sign = sign of the big operand; exponent = big exponent.
- NORM, one action per cycle, checked in this priority order:
  - carry bit set: shift right 1, exp+1.
  - magnitude == 0: result +0, go to OUT.
  - hidden bit clear and exp>1: shift left 1, exp-1.
  - hidden bit clear and exp==1 (underflow): result +0, go to OUT.
  - otherwise: pack {sign, exp, mantissa[22:0] truncated} into diff, go to OUT.
- Exponent overflow (exp reaches 255 after a carry shift) is handled in NORM; see Optional Feature.
- OUT:
  - out_valid=1 with diff stable;
  - on out_valid&&out_ready go to IDLE; out_valid drops on the same edge.
- Latency:
  - out_valid rises 4+k rising edges after the capture edge, where k = number of NORM shift cycles;
  - 0 <= k <= 24+GUARD_BITS.
  - Back-to-back throughput: one result per 5+k cycles with out_ready held high.
- in_ready=0 in every state except IDLE; in_valid outside IDLE is ignored.

Optional Feature:
- Macro: FLOAT_SUB_SPECIALS_EN.
- Defined, special operands are detected in IDLE capture and go straight to OUT in the next cycle:
  - any NaN input gives 0x7FC00000;
  - inf - inf with the same sign gives 0x7FC00000;
  - inf - finite gives that inf;
  - finite - inf gives inf with the opposite sign;
  - exponent overflow gives sign|0x7F800000.
- Undefined:
  - exp==255 operands are processed as ordinary finite numbers;
  - exponent overflow saturates to sign|0x7F7FFFFF.

Test Plan:
- 3.0-1.0: a=0x40400000, b=0x3F800000 -> diff=0x40000000, k=0, out_valid 4 edges after capture.
- Cancellation: 1.0-1.0, a=b=0x3F800000 -> diff=0x00000000 (+0); then 1.0-0.75, b=0x3F400000 -> diff=0x3E800000, k=2, out_valid 6 edges after capture.
- Carry: 1.0-(-1.0), b=0xBF800000 -> diff=0x40000000, k=1. Shift-out: 1.0-2^-30, b=0x30800000 -> diff=0x3F800000.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> diff and out_valid stable, in_ready=0, in_valid pulses ignored; raise out_ready -> IDLE next edge, in_ready=1.
- Reset in NORM: assert rst during the 1.0-0.75 run -> out_valid=0, diff=0, in_ready=1 immediately; the next op 3.0-1.0 gives 0x40000000.
- Specials and overflow:
  - with FLOAT_SUB_SPECIALS_EN: 0x7F800000-0x7F800000 -> 0x7FC00000; 0x7F7FFFFF-0xFF7FFFFF -> 0x7F800000.
  - without the macro: 0x7F7FFFFF-0xFF7FFFFF -> 0x7F7FFFFF.

Source files
------------

// File: rtl/float_subtractor.sv
// float_subtractor
//   Multi-cycle IEEE-754 single-precision subtractor: diff = a - b.
//   The sequence is IDLE -> ALIGN -> ADDSUB -> NORM (one or more cycles) -> OUT.
//   Rounding truncates toward zero. Denormal operands are flushed to zero.
//
//   Latency: out_valid becomes visible after 4+k rising edges, counting the
//   capture edge as the first. k is the number of NORM shift cycles. With
//   out_ready held high, a new operand pair is accepted every 5+k cycles.
//
//   Optional feature macro: FLOAT_SUB_SPECIALS_EN
//     defined   : NaN/inf operands bypass the datapath; overflow -> +/-inf
//     undefined : exp==255 operands are treated as finite; overflow
//                 saturates to +/-0x7F7FFFFF
//
// Parameters
//   GUARD_BITS  extra low-order mantissa bits kept through align/normalise (>=1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   a, b       operands (minuend, subtrahend), IEEE-754 single
//   in_valid   operands valid
//   in_ready   high only in IDLE
//   diff       registered result
//   out_valid  diff valid (state OUT)
//   out_ready  consumer accepts diff
module float_subtractor #(
  parameter int GUARD_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] diff,
  output logic        out_valid,
  input  logic        out_ready
);

  // Magnitude layout: [CB]=carry, [HB]=hidden bit, then 23 fraction bits,
  // then GUARD_BITS guard bits.
  localparam int MW = 24 + GUARD_BITS + 1;
  localparam int HB = MW - 2;
  localparam int CB = MW - 1;
  localparam logic [7:0] SHIFT_LIMIT = 8'(24 + GUARD_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADDSUB,
    S_NORM,
    S_OUT
  } state_t;

  state_t state_reg, state_next;

  // Operand unpacking. Subtraction is performed as a + (-b), so b's sign is
  // inverted here.
  logic [31:0]   op_word [2];
  logic [1:0]    in_sign;
  logic [7:0]    in_exp  [2];
  logic [MW-1:0] in_man  [2];

  assign op_word[0] = a;
  assign op_word[1] = {~b[31], b[30:0]};

`ifdef FLOAT_SUB_SPECIALS_EN
  logic [1:0] in_nan;
  logic [1:0] in_inf;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign in_sign[gi] = op_word[gi][31];
      assign in_exp[gi]  = op_word[gi][30:23];
      // exp==0 covers both zero and denormals: both become a zero magnitude.
      assign in_man[gi]  = (op_word[gi][30:23] == 8'd0) ? '0
                         : (MW'({2'b01, op_word[gi][22:0]}) << GUARD_BITS);
`ifdef FLOAT_SUB_SPECIALS_EN
      assign in_nan[gi]  = (op_word[gi][30:23] == 8'hFF) && (op_word[gi][22:0] != 23'd0);
      assign in_inf[gi]  = (op_word[gi][30:23] == 8'hFF) && (op_word[gi][22:0] == 23'd0);
`endif
    end
  endgenerate

  // Captured operands
  logic [1:0]         op_sign_reg, op_sign_next;
  logic [1:0][7:0]    op_exp_reg,  op_exp_next;
  logic [1:0][MW-1:0] op_man_reg,  op_man_next;

  // Aligned operands
  logic          big_sign_reg, big_sign_next;
  logic [7:0]    big_exp_reg,  big_exp_next;
  logic [MW-1:0] big_man_reg,  big_man_next;
  logic [MW-1:0] small_man_reg, small_man_next;
  logic          eff_sub_reg,  eff_sub_next;

  // Working result; 9-bit exponent so a carry out of exp 255 is still visible.
  logic          res_sign_reg, res_sign_next;
  logic [8:0]    res_exp_reg,  res_exp_next;
  logic [MW-1:0] res_man_reg,  res_man_next;

  logic [31:0]   diff_reg, diff_next;

  // Align helpers: larger magnitude decided by exponent, then mantissa.
  logic          a_is_big;
  logic [7:0]    sel_big_exp, sel_small_exp, exp_gap;
  logic [MW-1:0] sel_big_man, sel_small_man, small_aligned;

  assign a_is_big      = {op_exp_reg[0], op_man_reg[0]} >= {op_exp_reg[1], op_man_reg[1]};
  assign sel_big_exp   = a_is_big ? op_exp_reg[0] : op_exp_reg[1];
  assign sel_small_exp = a_is_big ? op_exp_reg[1] : op_exp_reg[0];
  assign sel_big_man   = a_is_big ? op_man_reg[0] : op_man_reg[1];
  assign sel_small_man = a_is_big ? op_man_reg[1] : op_man_reg[0];
  assign exp_gap       = sel_big_exp - sel_small_exp;
  // No sticky bit: anything shifted past the guard bits is simply lost.
  assign small_aligned = (exp_gap >= SHIFT_LIMIT) ? '0 : (sel_small_man >> exp_gap);

  logic [8:0] exp_inc, exp_dec;
  assign exp_inc = res_exp_reg + 9'd1;
  assign exp_dec = res_exp_reg - 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      op_sign_reg   <= '0;
      op_exp_reg    <= '0;
      op_man_reg    <= '0;
      big_sign_reg  <= 1'b0;
      big_exp_reg   <= '0;
      big_man_reg   <= '0;
      small_man_reg <= '0;
      eff_sub_reg   <= 1'b0;
      res_sign_reg  <= 1'b0;
      res_exp_reg   <= '0;
      res_man_reg   <= '0;
      diff_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      op_sign_reg   <= op_sign_next;
      op_exp_reg    <= op_exp_next;
      op_man_reg    <= op_man_next;
      big_sign_reg  <= big_sign_next;
      big_exp_reg   <= big_exp_next;
      big_man_reg   <= big_man_next;
      small_man_reg <= small_man_next;
      eff_sub_reg   <= eff_sub_next;
      res_sign_reg  <= res_sign_next;
      res_exp_reg   <= res_exp_next;
      res_man_reg   <= res_man_next;
      diff_reg      <= diff_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_sign_next   = op_sign_reg;
    op_exp_next    = op_exp_reg;
    op_man_next    = op_man_reg;
    big_sign_next  = big_sign_reg;
    big_exp_next   = big_exp_reg;
    big_man_next   = big_man_reg;
    small_man_next = small_man_reg;
    eff_sub_next   = eff_sub_reg;
    res_sign_next  = res_sign_reg;
    res_exp_next   = res_exp_reg;
    res_man_next   = res_man_reg;
    diff_next      = diff_reg;

    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 2; i++) begin
            op_sign_next[i] = in_sign[i];
            op_exp_next[i]  = in_exp[i];
            op_man_next[i]  = in_man[i];
          end
          state_next = S_ALIGN;
`ifdef FLOAT_SUB_SPECIALS_EN
          if (in_nan[0] || in_nan[1]) begin
            diff_next  = 32'h7FC0_0000;
            state_next = S_OUT;
          end else if (in_inf[0] && in_inf[1]) begin
            // Opposite effective signs means inf - inf of the same sign.
            diff_next  = (in_sign[0] != in_sign[1]) ? 32'h7FC0_0000 : op_word[0];
            state_next = S_OUT;
          end else if (in_inf[0]) begin
            diff_next  = op_word[0];
            state_next = S_OUT;
          end else if (in_inf[1]) begin
            // op_word[1] already carries the inverted sign of b.
            diff_next  = op_word[1];
            state_next = S_OUT;
          end
`endif
        end
      end

      S_ALIGN: begin
        big_sign_next  = a_is_big ? op_sign_reg[0] : op_sign_reg[1];
        big_exp_next   = sel_big_exp;
        big_man_next   = sel_big_man;
        small_man_next = small_aligned;
        eff_sub_next   = op_sign_reg[0] ^ op_sign_reg[1];
        state_next     = S_ADDSUB;
      end

      S_ADDSUB: begin
        // big >= small after alignment, so the difference is never negative.
        res_man_next  = eff_sub_reg ? (big_man_reg - small_man_reg)
                                    : (big_man_reg + small_man_reg);
        res_exp_next  = {1'b0, big_exp_reg};
        res_sign_next = big_sign_reg;
        state_next    = S_NORM;
      end

      S_NORM: begin
        if (res_man_reg[CB]) begin
          if (exp_inc >= 9'd255) begin
`ifdef FLOAT_SUB_SPECIALS_EN
            diff_next = {res_sign_reg, 8'hFF, 23'h000000};
`else
            diff_next = {res_sign_reg, 8'hFE, 23'h7FFFFF};
`endif
            state_next = S_OUT;
          end else begin
            res_man_next = res_man_reg >> 1;
            res_exp_next = exp_inc;
          end
        end else if (res_man_reg == '0) begin
          diff_next  = 32'h0000_0000;
          state_next = S_OUT;
        end else if (!res_man_reg[HB] && (res_exp_reg > 9'd1)) begin
          res_man_next = res_man_reg << 1;
          res_exp_next = exp_dec;
        end else if (!res_man_reg[HB]) begin
          // Would need a denormal: flush to +0.
          diff_next  = 32'h0000_0000;
          state_next = S_OUT;
        end else begin
          diff_next  = {res_sign_reg, res_exp_reg[7:0], res_man_reg[HB-1:GUARD_BITS]};
          state_next = S_OUT;
        end
      end

      S_OUT: begin
        if (out_ready) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_OUT);
  assign diff      = diff_reg;

endmodule

// File: tb/tb_float_subtractor.sv
module tb_float_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, diff;
  logic        in_valid, in_ready, out_valid, out_ready;

  always #5 clk = ~clk;

  float_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec     = 0;
  int n_miscmp  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          cap;
    string       tag;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] res;
    int          lat;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  // Output monitor: latency is the number of edges from the one before the
  // capture edge's negedge sample to the first negedge with out_valid high.
  logic prev_valid = 1'b0;
  int   rise_cyc   = 0;

  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", diff, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_diff"}, diff, e.res);
          chk({e.tag, "_lat"}, 32'(rise_cyc - e.cap), 32'(e.lat));
          $display("vector %s: a-b -> %h (expected %h), latency %0d", e.tag, diff, e.res, rise_cyc - e.cap);
        end
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] want,
                      input int lat, input string tag, input bit track, output int cap);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    cap      = cyc;
    if (track) sb.push_back('{res: want, lat: lat, cap: cyc, tag: tag});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int caps[$];
    int cap;
    int guard;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", diff, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    // lat = 4+k edges counted including the capture edge
    vecs.push_back('{av: 32'h40400000, bv: 32'h3F800000, res: 32'h40000000, lat: 4, tag: "3m1"});
    vecs.push_back('{av: 32'h3F800000, bv: 32'h3F800000, res: 32'h00000000, lat: 4, tag: "1m1"});
    vecs.push_back('{av: 32'h3F800000, bv: 32'h3F400000, res: 32'h3E800000, lat: 6, tag: "1m075"});
    vecs.push_back('{av: 32'h3F800000, bv: 32'hBF800000, res: 32'h40000000, lat: 5, tag: "carry"});
    vecs.push_back('{av: 32'h3F800000, bv: 32'h30800000, res: 32'h3F800000, lat: 4, tag: "shiftout"});
    vecs.push_back('{av: 32'h40000000, bv: 32'h40400000, res: 32'hBF800000, lat: 5, tag: "2m3"});
    vecs.push_back('{av: 32'h00000000, bv: 32'h40A00000, res: 32'hC0A00000, lat: 4, tag: "0m5"});
    vecs.push_back('{av: 32'h40A00000, bv: 32'h00000000, res: 32'h40A00000, lat: 4, tag: "5m0"});
    vecs.push_back('{av: 32'hBFC00000, bv: 32'h3E800000, res: 32'hBFE00000, lat: 4, tag: "neg_add"});
    vecs.push_back('{av: 32'h00400000, bv: 32'h00000000, res: 32'h00000000, lat: 4, tag: "denorm"});
    vecs.push_back('{av: 32'h00800001, bv: 32'h00800000, res: 32'h00000000, lat: 4, tag: "underflow"});
    vecs.push_back('{av: 32'h3F800000, bv: 32'h33000000, res: 32'h3F7FFFFF, lat: 5, tag: "trunc"});
`ifdef FLOAT_SUB_SPECIALS_EN
    vecs.push_back('{av: 32'h7F7FFFFF, bv: 32'hFF7FFFFF, res: 32'h7F800000, lat: 4, tag: "overflow"});
    vecs.push_back('{av: 32'h7F800000, bv: 32'h7F800000, res: 32'h7FC00000, lat: 1, tag: "inf_m_inf"});
    vecs.push_back('{av: 32'h7FC00001, bv: 32'h3F800000, res: 32'h7FC00000, lat: 1, tag: "nan"});
    vecs.push_back('{av: 32'h7F800000, bv: 32'h3F800000, res: 32'h7F800000, lat: 1, tag: "inf_m_1"});
    vecs.push_back('{av: 32'h3F800000, bv: 32'h7F800000, res: 32'hFF800000, lat: 1, tag: "1_m_inf"});
`else
    vecs.push_back('{av: 32'h7F7FFFFF, bv: 32'hFF7FFFFF, res: 32'h7F7FFFFF, lat: 4, tag: "overflow"});
`endif

    foreach (vecs[i]) begin
      send(vecs[i].av, vecs[i].bv, vecs[i].res, vecs[i].lat, vecs[i].tag, 1'b1, cap);
      caps.push_back(cap);
    end
    drain("table");
    // First vector has k=0, so the second capture follows 5 cycles later.
    chk("throughput", 32'(caps[1] - caps[0]), 32'd5);

    // Backpressure: result held in OUT while out_ready is low.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F400000, 32'h3E800000, 6, "bp", 1'b1, cap);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) chk("bp_out_valid_timeout", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_diff_hold", diff, 32'h3E800000);
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      a        = 32'h40400000;
      b        = 32'h3F800000;
      in_valid = (i % 2 == 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    drain("bp");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_no_phantom", 32'(out_valid), 32'd0);
    end

    // Reset during NORM aborts the operation with no output.
    send(32'h3F800000, 32'h3F400000, 32'h3E800000, 6, "rst_victim", 1'b0, cap);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", diff, 32'h0000_0000);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send(32'h40400000, 32'h3F800000, 32'h40000000, 4, "after_rst", 1'b1, cap);
    drain("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
